// File: rtl/mapper_mem_sequencer_pkg.sv
// Shared types and constants for the mapper-to-memory sequencer.
package mapper_mem_sequencer_pkg;

    // Sequencer states: waiting for a CPU access, request outstanding,
    // access finished but chip select still asserted.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } mem_seq_state_t;

    // Value returned to the CPU for reads that never completed.
    localparam logic [7:0] MEM_OPEN_BUS = 8'hFF;

    // Width of the acknowledge timeout counter (covers TIMEOUT up to 255).
    localparam int TMO_W = 8;

endpackage

// File: rtl/mapper_mem_sequencer_if.sv
// Bundle of mapper-side and memory-side signals around the sequencer.
// The master modport is the sequencer's view; slave is the view of the
// surrounding mapper / memory controller.
interface mapper_mem_sequencer_if #(
    parameter int ADDR_W = 27
);
    logic              ram_cs;
    logic [ADDR_W-1:0] addr;
    logic              rnw;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              cpu_wait;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              timeout_err;

    modport master (
        input  ram_cs, addr, rnw, cpu_din, mem_ack, mem_rdata,
        output cpu_dout, cpu_wait, mem_req, mem_addr, mem_we, mem_wdata,
               timeout_err
    );

    modport slave (
        output ram_cs, addr, rnw, cpu_din, mem_ack, mem_rdata,
        input  cpu_dout, cpu_wait, mem_req, mem_addr, mem_we, mem_wdata,
               timeout_err
    );
endinterface

// File: rtl/mapper_mem_sequencer_timeout.sv
// Loadable down-counter used to bound the wait for a memory acknowledge.
// zero_o flags the decrement that takes the counter to zero, so the
// caller can act in the same cycle the count expires.
import mapper_mem_sequencer_pkg::*;

module mem_seq_timeout (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [TMO_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;

    // Next count: load has priority; never wrap below zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    assign zero_o = dec_i && (count_q == TMO_W'(1));

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/mapper_mem_sequencer.sv
// Turns the mapper's level chip select into exactly one request/ack
// transaction per CPU access, stalling the CPU while it is outstanding
// and holding the returned read data.
import mapper_mem_sequencer_pkg::*;

module mapper_mem_sequencer #(
    parameter int ADDR_W  = 27,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    mapper_mem_sequencer_if.master bus
);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT);

    mem_seq_state_t    state_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [7:0]        mem_wdata_q;
    logic [7:0]        cpu_dout_q;
    logic              timeout_err_q;

    logic tmo_load;
    logic tmo_dec;
    logic tmo_zero;

    // Counter is armed when an access is accepted and runs only while
    // waiting; an ack in the expiry cycle suppresses the decrement so the
    // ack wins.
    assign tmo_load = (state_q == IDLE) && bus.ram_cs;
    assign tmo_dec  = (state_q == BUSY) && !bus.mem_ack;

    mem_seq_timeout u_timeout (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmo_load),
        .load_val_i (TMO_LOAD),
        .dec_i      (tmo_dec),
        .zero_o     (tmo_zero)
    );

    // Sequencer FSM with registered request fields and CPU read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '1;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            cpu_dout_q    <= MEM_OPEN_BUS;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ram_cs) begin
                        mem_addr_q  <= bus.addr;
                        mem_we_q    <= ~bus.rnw;
                        mem_wdata_q <= bus.cpu_din;
                        mem_req_q   <= 1'b1;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mem_ack) begin
                        if (!mem_we_q) begin
                            cpu_dout_q <= bus.mem_rdata;
                        end
                        mem_req_q <= 1'b0;
                        state_q   <= HOLD;
                    end else if (tmo_zero) begin
                        if (!mem_we_q) begin
                            cpu_dout_q <= MEM_OPEN_BUS;
                        end
                        timeout_err_q <= 1'b1;
                        mem_req_q     <= 1'b0;
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    // Stay here until the CPU cycle ends so a long chip
                    // select cannot trigger a second transaction.
                    if (!bus.ram_cs) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Stall starts combinationally in the cycle chip select rises.
    assign bus.cpu_wait    = ((state_q == IDLE) && bus.ram_cs) || (state_q == BUSY);
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.cpu_dout    = cpu_dout_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_mapper_mem_sequencer.sv
// Directed bench for mapper_mem_sequencer with TIMEOUT=4.
module tb_mapper_mem_sequencer;
    localparam int ADDR_W  = 27;
    localparam int TIMEOUT = 4;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    int              reqs, stall, unstable, reissue;
    logic [26:0]     f_addr;
    logic            f_we;
    logic [7:0]      f_wdata;

    mapper_mem_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    mapper_mem_sequencer #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One CPU access: raise chip select, answer the request with an ack
    // on the ack_at-th request cycle (0 = never), optionally keep chip
    // select high for `extra` more cycles, then end the CPU cycle.
    task automatic access(input logic rd, input logic [26:0] a, input logic [7:0] din,
                          input int ack_at, input logic [7:0] rdata, input int extra,
                          output int o_reqs, output int o_stall,
                          output logic [26:0] o_addr, output logic o_we,
                          output logic [7:0] o_wdata, output int o_unstable,
                          output int o_reissue);
        o_reqs = 0; o_stall = 0; o_unstable = 0; o_reissue = 0;
        o_addr = '0; o_we = 1'b0; o_wdata = '0;
        bus.ram_cs = 1'b1; bus.addr = a; bus.rnw = rd; bus.cpu_din = din;
        #1;
        if (bus.cpu_wait) o_stall++;
        for (int i = 0; i < 300; i++) begin
            tick();
            bus.mem_ack = 1'b0;
            if (!bus.mem_req) break;
            o_reqs++;
            if (bus.cpu_wait) o_stall++;
            if (o_reqs == 1) begin
                o_addr = bus.mem_addr; o_we = bus.mem_we; o_wdata = bus.mem_wdata;
                // Mapper inputs wander; latched fields must not follow.
                bus.addr = '1; bus.cpu_din = ~din; bus.rnw = ~rd;
            end else if (bus.mem_addr !== o_addr || bus.mem_we !== o_we ||
                         bus.mem_wdata !== o_wdata) begin
                o_unstable++;
            end
            if (o_reqs == ack_at) begin
                bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
            end
        end
        chk("wait_low_after_done", {31'd0, bus.cpu_wait}, 32'd0);
        for (int j = 0; j < extra; j++) begin
            tick();
            if (bus.mem_req || bus.cpu_wait) o_reissue++;
        end
        bus.ram_cs = 1'b0; bus.addr = '1; bus.rnw = 1'b1;
        tick();
        $display("access rd=%0b addr=%h reqs=%0d stall=%0d dout=%h terr=%0b",
                 rd, a, o_reqs, o_stall, bus.cpu_dout, bus.timeout_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.ram_cs = 1'b0; bus.addr = '1; bus.rnw = 1'b1; bus.cpu_din = 8'h00;
        bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
        tick();
        tick();

        // Reset values
        chk("rst_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("rst_addr",  {5'd0, bus.mem_addr}, 32'h07FF_FFFF);
        chk("rst_we",    {31'd0, bus.mem_we}, 32'd0);
        chk("rst_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        chk("rst_dout",  {24'd0, bus.cpu_dout}, 32'hFF);
        chk("rst_terr",  {31'd0, bus.timeout_err}, 32'd0);
        chk("rst_wait0", {31'd0, bus.cpu_wait}, 32'd0);
        bus.ram_cs = 1'b1; #1;
        chk("rst_wait1", {31'd0, bus.cpu_wait}, 32'd1);
        bus.ram_cs = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Read, ack on the 3rd request cycle
        access(1'b1, 27'h0004123, 8'h00, 3, 8'h5A, 0,
               reqs, stall, f_addr, f_we, f_wdata, unstable, reissue);
        chk("rd_reqs",   reqs, 3);
        chk("rd_stall",  stall, 4);
        chk("rd_addr",   {5'd0, f_addr}, 32'h0004123);
        chk("rd_we",     {31'd0, f_we}, 32'd0);
        chk("rd_stable", unstable, 0);
        chk("rd_dout",   {24'd0, bus.cpu_dout}, 32'h5A);

        // Write, ack in the first request cycle
        access(1'b0, 27'h1234567, 8'hC3, 1, 8'h77, 0,
               reqs, stall, f_addr, f_we, f_wdata, unstable, reissue);
        chk("wr_reqs",  reqs, 1);
        chk("wr_stall", stall, 2);
        chk("wr_addr",  {5'd0, f_addr}, 32'h1234567);
        chk("wr_we",    {31'd0, f_we}, 32'd1);
        chk("wr_wdata", {24'd0, f_wdata}, 32'hC3);
        chk("wr_dout",  {24'd0, bus.cpu_dout}, 32'h5A);

        // Stray ack while idle is ignored
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h11;
        tick();
        bus.mem_ack = 1'b0;
        chk("idle_ack_req",  {31'd0, bus.mem_req}, 32'd0);
        chk("idle_ack_dout", {24'd0, bus.cpu_dout}, 32'h5A);

        // Chip select held 20 cycles, ack after 2: one transaction only
        access(1'b1, 27'h0000200, 8'h00, 2, 8'h81, 16,
               reqs, stall, f_addr, f_we, f_wdata, unstable, reissue);
        chk("hold_reqs",    reqs, 2);
        chk("hold_reissue", reissue, 0);
        chk("hold_dout",    {24'd0, bus.cpu_dout}, 32'h81);

        // Ack coincides with the counter expiring: ack wins
        access(1'b1, 27'h0000300, 8'h00, 4, 8'h96, 0,
               reqs, stall, f_addr, f_we, f_wdata, unstable, reissue);
        chk("edge_reqs", reqs, 4);
        chk("edge_dout", {24'd0, bus.cpu_dout}, 32'h96);
        chk("edge_terr", {31'd0, bus.timeout_err}, 32'd0);

        // No ack at all: timeout after 4 request cycles
        access(1'b1, 27'h0000400, 8'h00, 0, 8'h00, 0,
               reqs, stall, f_addr, f_we, f_wdata, unstable, reissue);
        chk("tmo_reqs",  reqs, 4);
        chk("tmo_stall", stall, 5);
        chk("tmo_dout",  {24'd0, bus.cpu_dout}, 32'hFF);
        chk("tmo_terr",  {31'd0, bus.timeout_err}, 32'd1);

        // Error flag is sticky across a good access
        access(1'b1, 27'h0000500, 8'h00, 2, 8'h3C, 0,
               reqs, stall, f_addr, f_we, f_wdata, unstable, reissue);
        chk("sticky_dout", {24'd0, bus.cpu_dout}, 32'h3C);
        chk("sticky_terr", {31'd0, bus.timeout_err}, 32'd1);

        // Reset in the 2nd BUSY cycle
        bus.ram_cs = 1'b1; bus.addr = 27'h0000ABC; bus.rnw = 1'b1;
        tick();
        tick();
        chk("mid_req_before", {31'd0, bus.mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_req",  {31'd0, bus.mem_req}, 32'd0);
        chk("mid_dout", {24'd0, bus.cpu_dout}, 32'hFF);
        chk("mid_terr", {31'd0, bus.timeout_err}, 32'd0);
        chk("mid_addr", {5'd0, bus.mem_addr}, 32'h07FF_FFFF);
        bus.ram_cs = 1'b0; bus.addr = '1;
        tick();
        reset = 1'b0;
        tick();

        // Fresh access after reset
        access(1'b1, 27'h0000ABC, 8'h00, 1, 8'hA5, 0,
               reqs, stall, f_addr, f_we, f_wdata, unstable, reissue);
        chk("post_reqs", reqs, 1);
        chk("post_addr", {5'd0, f_addr}, 32'h0000ABC);
        chk("post_dout", {24'd0, bus.cpu_dout}, 32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
